// File: rtl/div_pkg.sv
// Shared state encoding and default parameters for the sequential divider.
package div_pkg;

    localparam int DEFAULT_WIDTH           = 32;
    localparam int DEFAULT_STEPS_PER_CYCLE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    function automatic int run_cycles(input int width, input int steps);
        return width / steps;
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring division step on the {PR,Q} register pair.
module nr_div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   pr_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   pr_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] pr_shift;

    // The add/subtract decision uses the sign before the shift; the WIDTH+1-bit
    // wrap of the shifted value is harmless because the true result fits.
    always_comb begin
        pr_shift = {pr_in[WIDTH-1:0], q_in[WIDTH-1]};
        if (pr_in[WIDTH]) begin
            pr_out = pr_shift + {1'b0, divisor};
        end else begin
            pr_out = pr_shift - {1'b0, divisor};
        end
        q_out = {q_in[WIDTH-2:0], ~pr_out[WIDTH]};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider: IDLE -> RUN -> FIX -> DONE, with a
// chain of STEPS_PER_CYCLE non-restoring steps evaluated per RUN cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int STEPS_PER_CYCLE = DEFAULT_STEPS_PER_CYCLE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int N     = run_cycles(WIDTH, STEPS_PER_CYCLE);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    div_state_t       state_reg;
    logic [WIDTH:0]   pr_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic [WIDTH:0]   pr_chain [0:STEPS_PER_CYCLE];
    logic [WIDTH-1:0] q_chain  [0:STEPS_PER_CYCLE];

    // The DONE cycle behaves as idle so back-to-back operations lose no cycle.
    assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    always_comb begin
        a_neg = is_signed & dividend[WIDTH-1];
        b_neg = is_signed & divisor[WIDTH-1];
        a_mag = a_neg ? -dividend : dividend;
        b_mag = b_neg ? -divisor  : divisor;
    end

    assign pr_chain[0] = pr_reg;
    assign q_chain[0]  = q_reg;

    generate
        for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
            nr_div_step #(
                .WIDTH(WIDTH)
            ) u_step (
                .pr_in  (pr_chain[gi]),
                .q_in   (q_chain[gi]),
                .divisor(d_reg),
                .pr_out (pr_chain[gi+1]),
                .q_out  (q_chain[gi+1])
            );
        end
    endgenerate

    // Final remainder correction and sign application, all modulo 2^WIDTH.
    always_comb begin
        r_mag = pr_reg[WIDTH] ? (pr_reg[WIDTH-1:0] + d_reg) : pr_reg[WIDTH-1:0];
        q_fix = q_neg_reg ? -q_reg : q_reg;
        r_fix = r_neg_reg ? -r_mag : r_mag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pr_reg        <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        pr_reg    <= '0;
                        q_reg     <= a_mag;
                        d_reg     <= b_mag;
                        q_neg_reg <= a_neg ^ b_neg;
                        r_neg_reg <= a_neg;
                        cnt_reg   <= '0;
                        if (divisor == '0) begin
                            state_reg     <= ST_DONE;
                            done_reg      <= 1'b1;
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                            dbz_reg   <= 1'b0;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    pr_reg  <= pr_chain[STEPS_PER_CYCLE];
                    q_reg   <= q_chain[STEPS_PER_CYCLE];
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_reg     <= ST_DONE;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b1;
                    quotient_reg  <= q_fix;
                    remainder_reg <= r_fix;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench: two dividers (1 and 4 steps per cycle) checked against
// plain integer division, with latency, busy window, abort and hold scenarios.
module tb_seq_divider;

    localparam int W      = 32;
    localparam int LAT1   = W / 1 + 2;
    localparam int LAT4   = W / 4 + 2;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           issue;
        int           due;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         start1;
    logic         start4;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;

    logic         busy1, done1, dbz1;
    logic [W-1:0] quot1, rem1;
    logic         busy4, done4, dbz4;
    logic [W-1:0] quot4, rem4;

    exp_t exp1_q[$];
    exp_t exp4_q[$];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic chk_zero_req = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    seq_divider #(.WIDTH(W), .STEPS_PER_CYCLE(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy1), .done(done1),
        .quotient(quot1), .remainder(rem1), .div_by_zero(dbz1)
    );

    seq_divider #(.WIDTH(W), .STEPS_PER_CYCLE(4)) u_dut4 (
        .clock(clock), .reset(reset), .start(start4), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy4), .done(done4),
        .quotient(quot4), .remainder(rem4), .div_by_zero(dbz4)
    );

    // Reference: integer division truncating toward zero, remainder takes the
    // dividend's sign; divide-by-zero returns all ones and the dividend.
    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        e.issue = 0;
        e.due   = 0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (sgn) begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            e.q   = 32'(sa / sb);
            e.r   = 32'(sa % sb);
            e.dbz = 1'b0;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input int dut, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%08h, expected 0x%08h", name, dut, cyc, act, exp);
        end
    endtask

    task automatic mon_dut(input int idx, input logic done, input logic busy,
                           input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        bit   have;
        have = (idx == 1) ? (exp1_q.size() != 0) : (exp4_q.size() != 0);
        if (have) e = (idx == 1) ? exp1_q[0] : exp4_q[0];
        if (done === 1'b1) begin
            if (!have) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done dut%0d cycle %0d: got done=1, expected done=0", idx, cyc);
            end else begin
                if (idx == 1) void'(exp1_q.pop_front()); else void'(exp4_q.pop_front());
                $display("dut%0d done cycle %0d: q=0x%08h r=0x%08h dbz=%0b (exp q=0x%08h r=0x%08h dbz=%0b)",
                         idx, cyc, q, r, dbz, e.q, e.r, e.dbz);
                check("latency", idx, cyc, e.due);
                check("quotient", idx, q, e.q);
                check("remainder", idx, r, e.r);
                check("div_by_zero", idx, {31'd0, dbz}, {31'd0, e.dbz});
                check("busy_at_done", idx, {31'd0, busy}, 32'd0);
            end
        end else if (have) begin
            if (cyc >= e.due) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_timeout dut%0d cycle %0d: got no done, expected done at cycle %0d", idx, cyc, e.due);
                if (idx == 1) void'(exp1_q.pop_front()); else void'(exp4_q.pop_front());
            end else if ((e.due - e.issue > 1) && (cyc > e.issue)) begin
                check("busy_window", idx, {31'd0, busy}, 32'd1);
                check("dbz_cleared", idx, {31'd0, dbz}, 32'd0);
            end
        end
    endtask

    // Monitor: sole owner of the check counters.
    always @(negedge clock) begin
        if (chk_zero_req) begin
            check("rst_busy", 1, {31'd0, busy1}, 32'd0);
            check("rst_done", 1, {31'd0, done1}, 32'd0);
            check("rst_quotient", 1, quot1, 32'd0);
            check("rst_remainder", 1, rem1, 32'd0);
            check("rst_dbz", 1, {31'd0, dbz1}, 32'd0);
            check("rst_busy", 4, {31'd0, busy4}, 32'd0);
            check("rst_quotient", 4, quot4, 32'd0);
            check("rst_remainder", 4, rem4, 32'd0);
        end
        mon_dut(1, done1, busy1, quot1, rem1, dbz1);
        mon_dut(4, done4, busy4, quot4, rem4, dbz4);
    end

    // Called at a falling edge; start is sampled at the following rising edge.
    task automatic issue(input bit to1, input bit to4, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start1    = to1;
        start4    = to4;
        e = model(sgn, a, b);
        e.issue = cyc;
        if (to1) begin
            e.due = cyc + ((b == '0) ? 1 : LAT1);
            exp1_q.push_back(e);
        end
        if (to4) begin
            e.due = cyc + ((b == '0) ? 1 : LAT4);
            exp4_q.push_back(e);
        end
        @(negedge clock);
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (exp1_q.size() != 0 || exp4_q.size() != 0); i++) begin
            @(negedge clock);
        end
    endtask

    task automatic apply_reset_and_check();
        reset = 1'b1;
        @(posedge clock);
        #1 chk_zero_req = 1'b1;
        @(negedge clock);
        #1 chk_zero_req = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset     = 1'b1;
        start1    = 1'b0;
        start4    = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        @(posedge clock);
        apply_reset_and_check();

        issue(1, 1, 1'b0, 32'd100, 32'd7);                    wait_idle();
        issue(1, 1, 1'b1, 32'hFFFF_FFF9, 32'd2);              wait_idle();
        issue(1, 1, 1'b1, 32'd7, 32'hFFFF_FFFE);              wait_idle();
        issue(1, 1, 1'b0, 32'd55, 32'd0);                     wait_idle();
        issue(1, 1, 1'b0, 32'd9, 32'd3);                      wait_idle();
        issue(1, 1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);      wait_idle();
        issue(1, 1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);      wait_idle();
        issue(1, 1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010);      wait_idle();
        issue(1, 1, 1'b1, 32'd0, 32'd0);                      wait_idle();

        for (int n = 0; n < 50; n++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            issue(1, 1, 1'($urandom_range(0, 1)), a, b);
            wait_idle();
        end

        // start held high through the busy window must not restart dut1
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd33;
        start1    = 1'b1;
        begin
            exp_t e;
            e = model(1'b0, 32'd1000, 32'd33);
            e.issue = cyc;
            e.due   = cyc + LAT1;
            exp1_q.push_back(e);
        end
        repeat (20) @(negedge clock);
        start1 = 1'b0;
        wait_idle();

        // abort: reset 10 cycles into an operation; no done may follow
        repeat (2) @(negedge clock);
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        start1    = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        repeat (9) @(negedge clock);
        apply_reset_and_check();
        repeat (40) @(negedge clock);

        issue(1, 1, 1'b0, 32'd100, 32'd7);
        wait_idle();
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >= 4).
REQ-002 SHALL have parameter STEPS_PER_CYCLE, default 1, non-restoring steps per clock; WIDTH % STEPS_PER_CYCLE == 0.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-008 SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port quotient  output  WIDTH  registered, held until next accepted start.
REQ-012 SHALL have port remainder  output  WIDTH  registered, held until next accepted start.
REQ-013 SHALL have port div_by_zero  output  1  registered flag, held with results.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> FIX -> DONE -> IDLE; IDLE -> DONE directly on divide-by-zero.
REQ-015 SHALL, in IDLE with start=1, latch operands as magnitudes (signed mode: negate negative operands), result signs (q sign = dividend sign XOR divisor sign, r sign = dividend sign), clear WIDTH+1-bit partial remainder.
REQ-016 SHALL, in RUN, perform STEPS_PER_CYCLE non-restoring steps per cycle: shift {PR,Q} left 1; subtract divisor if PR >= 0 else add; new quotient LSB = NOT sign(PR); remain in RUN exactly N = WIDTH/STEPS_PER_CYCLE cycles.
REQ-017 SHALL, in FIX, add divisor to PR if negative, then apply result signs with WIDTH-bit wrap.
REQ-018 SHALL, in DONE, assert done=1 for exactly one cycle, with quotient/remainder/div_by_zero updated in that same cycle.
REQ-019 SHALL give latency: start accepted at edge T -> done high in cycle T+N+2.
REQ-020 SHALL treat divisor=0: quotient=all ones, remainder=dividend, div_by_zero=1, done in cycle T+1.
REQ-021 SHALL produce signed MIN / -1: quotient=MIN (wrapped), remainder=0, div_by_zero=0, normal latency.
REQ-022 SHALL ignore start while busy=1; in-flight operation unaffected.
REQ-023 SHALL accept start in the cycle done is high (done cycle counts as idle), and SHALL deassert busy in that cycle.
REQ-024 SHALL clear div_by_zero on every accepted start.

Reset
REQ-025 SHALL, with reset=1 at an edge, force IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-026 SHALL abort any in-flight operation on reset, with no done pulse produced for it.
REQ-027 SHALL give reset priority over start in the same cycle.

Structure
REQ-028 SHALL place the FSM state enum and default-parameter constants in the shared package div_pkg.
REQ-029 SHALL use one combinational sub-module nr_div_step (parameter WIDTH), instantiated STEPS_PER_CYCLE times in a chain.

Verification
REQ-030 SHALL test: WIDTH=32, unsigned 100/7, start at T -> done at T+34, q=14, r=2.
REQ-031 SHALL test: signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
REQ-032 SHALL test: 55/0 -> done at T+1, q=0xFFFFFFFF, r=55, div_by_zero=1; next 9/3 start -> div_by_zero=0, q=3, r=0.
REQ-033 SHALL test: signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned same operands -> q=0, r=0x80000000.
REQ-034 SHALL test: reset asserted 10 cycles after start -> busy=0, all outputs 0 next cycle, no done pulse; start held high during busy does not restart.
REQ-035 SHALL test: STEPS_PER_CYCLE=4, unsigned 0xFFFFFFFF/0x10 -> done at T+10, q=0x0FFFFFFF, r=0xF.
